// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory for the single-cycle core.
// Word-addressed RAM plus a peripheral window at MMIO_BASE that holds an LED
// register, a free-running 32-bit timer with a sticky compare flag, and a
// byte-wide transmit FIFO drained through a valid/ready port.
// Reads are purely combinational and have no side effects. All state changes
// happen on the rising clock edge.
module dmem_mmio #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [7:0]  led,
  output logic        timer_irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [4:0] OFF_LED    = 5'h00;
  localparam logic [4:0] OFF_TCOUNT = 5'h04;
  localparam logic [4:0] OFF_TCMP   = 5'h08;
  localparam logic [4:0] OFF_TSTAT  = 5'h0C;
  localparam logic [4:0] OFF_TXDATA = 5'h10;
  localparam logic [4:0] OFF_TXSTAT = 5'h14;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          in_ram;
  logic          in_mmio;
  logic [AW-1:0] ram_idx;
  logic [4:0]    off;

  assign in_ram  = (a < RAM_BYTES);
  assign in_mmio = (a[31:5] == MMIO_BASE[31:5]);
  assign ram_idx = a[AW+1:2];
  assign off     = a[4:0];

  logic wr_ram;
  logic wr_led;
  logic wr_tcount;
  logic wr_tcmp;
  logic wr_tstat;
  logic wr_txdata;
  logic wr_txstat;

  assign wr_ram    = we && in_ram;
  assign wr_led    = we && in_mmio && (off == OFF_LED);
  assign wr_tcount = we && in_mmio && (off == OFF_TCOUNT);
  assign wr_tcmp   = we && in_mmio && (off == OFF_TCMP);
  assign wr_tstat  = we && in_mmio && (off == OFF_TSTAT);
  assign wr_txdata = we && in_mmio && (off == OFF_TXDATA);
  assign wr_txstat = we && in_mmio && (off == OFF_TXSTAT);

  // ---------------------------------------------------------------------------
  // Data RAM (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  // RAM word write; no reset so program data survives a core restart.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= wd;
    end
  end

  // ---------------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------------
  logic [7:0] led_q;

  // LED register: low byte of the write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= 8'h00;
    end else if (wr_led) begin
      led_q <= wd[7:0];
    end
  end

  assign led = led_q;

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        match_flag;

  // Timer count/compare; a match sets the sticky flag and beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount     <= 32'h0000_0000;
      tcmp       <= 32'hFFFF_FFFF;
      match_flag <= 1'b0;
    end else begin
      if (wr_tcount) begin
        tcount <= wd;
      end else begin
        tcount <= tcount + 32'd1;
      end
      if (wr_tcmp) begin
        tcmp <= wd;
      end
      if (tcount == tcmp) begin
        match_flag <= 1'b1;
      end else if (wr_tstat && wd[0]) begin
        match_flag <= 1'b0;
      end
    end
  end

  assign timer_irq = match_flag;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] occ;
  logic          ovf_flag;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_ok;
  logic          push_drop;

  assign fifo_full  = (occ == CW'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);
  // tx_valid comes only from registered occupancy, never from tx_ready.
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_empty ? 8'h00 : fifo_mem[rptr];
  assign pop        = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
  assign push_ok    = wr_txdata && (!fifo_full || pop);
  assign push_drop  = wr_txdata && fifo_full && !pop;

  // FIFO storage; entries past the read pointer are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr] <= wd[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag (set beats W1C).
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (push_drop) begin
        ovf_flag <= 1'b1;
      end else if (wr_txstat && wd[2]) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] txstat;

  assign txstat = {24'h000000, 4'(occ), 1'b0, ovf_flag, fifo_empty, fifo_full};

  // Combinational read path; unmapped addresses and unused offsets return zero.
  always_comb begin
    rd = 32'h0000_0000;
    if (in_ram) begin
      rd = ram[ram_idx];
    end else if (in_mmio) begin
      case (off)
        OFF_LED:    rd = {24'h000000, led_q};
        OFF_TCOUNT: rd = tcount;
        OFF_TCMP:   rd = tcmp;
        OFF_TSTAT:  rd = {31'h0, match_flag};
        OFF_TXSTAT: rd = txstat;
        default:    rd = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue/array model.
module tb_dmem_mmio;

  localparam logic [31:0] MB      = 32'hFFFF_0000;
  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_TC    = 32'hFFFF_0004;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_0008;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_000C;
  localparam logic [31:0] A_TXD   = 32'hFFFF_0010;
  localparam logic [31:0] A_TXS   = 32'hFFFF_0014;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic [7:0]  led;
  logic        timer_irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .rd(rd), .led(led),
    .timer_irq(timer_irq), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Behavioural model
  logic [31:0] m_ram [64];
  bit          m_ram_v [64];
  logic [7:0]  m_led;
  logic [31:0] m_tc;
  logic [31:0] m_tcmp;
  bit          m_match;
  bit          m_ovf;
  logic [7:0]  m_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] ad, output bit known);
    logic [31:0] v;
    known = 1'b1;
    v = 32'h0;
    if (ad < 32'd256) begin
      known = m_ram_v[ad[7:2]];
      v = m_ram[ad[7:2]];
    end else if (ad[31:5] == MB[31:5]) begin
      case (ad[4:0])
        5'h00: v = {24'h0, m_led};
        5'h04: v = m_tc;
        5'h08: v = m_tcmp;
        5'h0C: v = {31'h0, m_match};
        5'h14: v = {24'h0, 4'(m_q.size()), 1'b0, m_ovf,
                    (m_q.size() == 0), (m_q.size() == 4)};
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic model_step();
    bit mm;
    bit pop;
    bit full;
    bit oset;
    bit push_req;
    logic [4:0] o;
    if (reset) begin
      m_led = 8'h00;
      m_tc = 32'h0;
      m_tcmp = 32'hFFFF_FFFF;
      m_match = 0;
      m_ovf = 0;
      m_q.delete();
    end else begin
      mm = (a[31:5] == MB[31:5]);
      o = a[4:0];
      pop = (m_q.size() > 0) && tx_ready;
      full = (m_q.size() == 4);
      if (m_tc == m_tcmp) m_match = 1;
      else if (we && mm && o == 5'h0C && wd[0]) m_match = 0;
      if (we && mm && o == 5'h04) m_tc = wd;
      else m_tc = m_tc + 32'd1;
      if (we && mm && o == 5'h08) m_tcmp = wd;
      if (we && mm && o == 5'h00) m_led = wd[7:0];
      if (we && a < 32'd256) begin
        m_ram[a[7:2]] = wd;
        m_ram_v[a[7:2]] = 1;
      end
      push_req = we && mm && o == 5'h10;
      if (pop) void'(m_q.pop_front());
      oset = 0;
      if (push_req) begin
        if (!full || pop) m_q.push_back(wd[7:0]);
        else oset = 1;
      end
      if (oset) m_ovf = 1;
      else if (we && mm && o == 5'h14 && wd[2]) m_ovf = 0;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  bit          c_known;
  logic [31:0] c_exp;
  always @(negedge clk) begin
    if (chk_en) begin
      c_exp = model_rd(a, c_known);
      if (c_known) chk("rd", rd, c_exp);
      chk("led", {24'h0, led}, {24'h0, m_led});
      chk("timer_irq", 32'(timer_irq), 32'(m_match));
      chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      chk("tx_data", {24'h0, tx_data}, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
    end
  end

  task automatic set_in(input logic r, input logic [31:0] ad, input logic [31:0] d,
                        input logic w, input logic rdy);
    reset = r;
    a = ad;
    wd = d;
    we = w;
    tx_ready = rdy;
    #2;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp4 [4];
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < 64; i++) m_ram_v[i] = 0;
    set_in(1, 32'h0, 32'h0, 0, 0);
    tick();
    chk_en = 1;
    tick();

    // Reset state and basic decode
    set_in(0, A_TCMP, 32'h0, 0, 0);
    chk("tcmp_rst", rd, 32'hFFFF_FFFF);
    chk("irq_rst", 32'(timer_irq), 32'h0);
    chk("txv_rst", 32'(tx_valid), 32'h0);
    tick();
    set_in(0, 32'h10, 32'hDEAD_BEEF, 1, 0); tick();
    set_in(0, 32'h10, 32'h0, 0, 0);
    chk("ram_rd", rd, 32'hDEAD_BEEF); tick();
    set_in(0, A_TXD, 32'h0, 0, 0);
    chk("txdata_rd", rd, 32'h0); tick();
    set_in(0, 32'h1000, 32'h0, 0, 0);
    chk("unmapped_rd", rd, 32'h0); tick();

    // Timer compare and wrap
    set_in(1, 32'h0, 32'h0, 0, 0); tick();
    set_in(0, A_TC, 32'd5, 1, 0); tick();
    set_in(0, A_TCMP, 32'd8, 1, 0); tick();
    for (int i = 6; i <= 8; i++) begin
      set_in(0, A_TC, 32'h0, 0, 0);
      chk("tcount_seq", rd, 32'(i));
      chk("irq_pre", 32'(timer_irq), 32'h0);
      tick();
    end
    set_in(0, A_TSTAT, 32'h1, 1, 0);
    chk("irq_set", 32'(timer_irq), 32'h1);
    chk("tstat_rd", rd, 32'h1); tick();
    set_in(0, A_TSTAT, 32'h0, 0, 0);
    chk("irq_clr", 32'(timer_irq), 32'h0); tick();
    set_in(0, A_TC, 32'hFFFF_FFFF, 1, 0); tick();
    set_in(0, A_TC, 32'h0, 0, 0);
    chk("tc_max", rd, 32'hFFFF_FFFF); tick();
    set_in(0, A_TC, 32'h0, 0, 0);
    chk("tc_wrap", rd, 32'h0); tick();

    // FIFO fill, overflow, drain
    for (int v = 8'h41; v <= 8'h44; v++) begin
      set_in(0, A_TXD, 32'(v), 1, 0); tick();
    end
    set_in(0, A_TXS, 32'h0, 0, 0);
    chk("txstat_full", rd, 32'h41); tick();
    set_in(0, A_TXD, 32'h45, 1, 0); tick();
    set_in(0, A_TXS, 32'h0, 0, 0);
    chk("txstat_ovf", rd, 32'h45);
    chk("tx_head", {24'h0, tx_data}, 32'h41); tick();
    for (int k = 0; k < 4; k++) begin
      set_in(0, A_TXS, 32'h0, 0, 1);
      chk("drain_seq", {24'h0, tx_data}, 32'(8'h41 + k));
      chk("drain_valid", 32'(tx_valid), 32'h1);
      tick();
    end
    set_in(0, A_TXS, 32'h4, 1, 1);
    chk("txv_empty", 32'(tx_valid), 32'h0);
    chk("txstat_empty", rd, 32'h06); tick();
    set_in(0, A_TXS, 32'h0, 0, 0);
    chk("ovf_clr", rd, 32'h02); tick();

    // Push into a full FIFO while it is being popped
    for (int v = 8'h61; v <= 8'h64; v++) begin
      set_in(0, A_TXD, 32'(v), 1, 0); tick();
    end
    set_in(0, A_TXD, 32'h55, 1, 1);
    chk("full_head", {24'h0, tx_data}, 32'h61); tick();
    set_in(0, A_TXS, 32'h0, 0, 0);
    chk("full_pushpop", rd, 32'h41); tick();
    exp4[0] = 8'h62; exp4[1] = 8'h63; exp4[2] = 8'h64; exp4[3] = 8'h55;
    for (int k = 0; k < 4; k++) begin
      set_in(0, A_TXS, 32'h0, 0, 1);
      chk("drain_pp", {24'h0, tx_data}, {24'h0, exp4[k]});
      tick();
    end
    set_in(0, A_TXS, 32'h0, 0, 0);
    chk("empty_after", rd, 32'h02); tick();

    // LED and reset mid-drain
    set_in(0, A_LED, 32'h1A5, 1, 0); tick();
    set_in(0, A_LED, 32'h0, 0, 0);
    chk("led_out", {24'h0, led}, 32'hA5);
    chk("led_rd", rd, 32'hA5); tick();
    set_in(0, A_TXD, 32'h71, 1, 0); tick();
    set_in(0, A_TXD, 32'h72, 1, 0); tick();
    set_in(0, A_TXS, 32'h0, 0, 1); tick();
    set_in(1, A_TXS, 32'h0, 0, 1);
    chk("txv_pre_rst", 32'(tx_valid), 32'h1); tick();
    set_in(0, 32'h10, 32'h0, 0, 0);
    chk("led_rst", {24'h0, led}, 32'h0);
    chk("txv_rst2", 32'(tx_valid), 32'h0);
    chk("txd_rst2", {24'h0, tx_data}, 32'h0);
    chk("ram_keep", rd, 32'hDEAD_BEEF); tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic w;
      logic [31:0] d;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ra = 32'($urandom_range(0, 255));
        4, 5, 6, 7, 8: begin
          if ($urandom_range(0, 3) == 0) ra = MB | 32'($urandom_range(0, 31));
          else ra = MB | 32'(4 * $urandom_range(0, 5));
        end
        default: begin
          case ($urandom_range(0, 4))
            0: ra = 32'h100;
            1: ra = 32'h1000;
            2: ra = 32'hFFFE_FFFC;
            3: ra = 32'hFFFF_0020;
            default: ra = $urandom | 32'h8000_0000;
          endcase
        end
      endcase
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      r = ($urandom_range(0, 63) == 0);
      w = r ? 1'b0 : 1'($urandom_range(0, 1));
      set_in(r, ra, d, w, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
